mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: ADDR_W default 32, memory address width; DATA_W default 32, data width; TIMEOUT default 255, maximum BUSY cycles waiting for mem_ack.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 i_req  in  1  instruction-fetch read request; held with i_addr until i_ready.
REQ-005 i_addr  in  ADDR_W  fetch address.
REQ-006 i_ready  out  1  fetch request accepted this cycle.
REQ-007 i_rvalid, i_err  out  1 each  fetch response valid / response is a timeout error.
REQ-008 i_rdata  out  DATA_W  fetch read data.
REQ-009 d_req, d_we  in  1 each  data request / write-enable; held with d_addr, d_wdata, d_wstrb until d_ready.
REQ-010 d_addr  in  ADDR_W; d_wdata  in  DATA_W; d_wstrb  in  DATA_W/8  data-port request fields.
REQ-011 d_ready, d_rvalid, d_err  out  1 each; d_rdata  out  DATA_W  data-port accept / response / error / read data.
REQ-012 mem_req, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_wstrb  out  DATA_W/8  single shared memory port.
REQ-013 mem_ack  in  1  memory completion, one-cycle pulse; mem_rdata  in  DATA_W  valid with mem_ack.

Function
REQ-014 FSM states IDLE, BUSY, RESP; at most one transaction outstanding.
REQ-015 IDLE: if either request is high, the winner's ready is driven combinationally high in that same cycle; loser's ready stays low; next state BUSY.
REQ-016 Arbitration: a single requester always wins; on a tie, the port not granted last wins (round-robin); last_grant updates on every grant.
REQ-017 On grant, the winner's fields are registered into mem_* (fetch: mem_we=0, mem_wstrb=0, mem_wdata=0); mem_req is high from the next cycle for the whole of BUSY.
REQ-018 BUSY: mem_ack high -> mem_rdata latched (0 for writes), err=0, next state RESP; mem_req low in RESP.
REQ-019 BUSY: timeout counter increments each cycle; when it reaches TIMEOUT without mem_ack -> err=1, rdata=0, next state RESP.
REQ-020 mem_ack arriving on the same cycle the counter reaches TIMEOUT counts as success.
REQ-021 RESP: the granted port's rvalid is high for exactly one cycle, with rdata and err; the other port's rvalid stays low; next state IDLE.
REQ-022 Writes also receive an rvalid completion; rdata=0.
REQ-023 Requests are not accepted in BUSY or RESP; minimum spacing between two grants is 3 cycles (grant N, ack N+1, rvalid N+2, next grant N+3).
REQ-024 mem_ack outside BUSY is ignored.
REQ-025 rdata outputs hold their last value when rvalid is low; the counter clears on every grant.

Reset
REQ-026 Asserting rst forces IDLE immediately: mem_req, mem_we, all ready/rvalid/err = 0; mem_addr, mem_wdata, mem_wstrb, rdata = 0; counter = 0; last_grant = data port, so the first tie goes to fetch.
REQ-027 Reset during BUSY or RESP abandons the transaction: no rvalid is produced, and a later mem_ack is ignored.

Structure
REQ-028 Shared package mem_arb_pkg holds the state enum (IDLE, BUSY, RESP) and the port-id enum (PORT_I, PORT_D).
REQ-029 One sub-module, rr_arbiter2: a combinational two-request pick from last_grant, producing grant and port id; the FSM, capture registers and timeout counter live in mem_arbiter.

Verification
REQ-030 i_req only, addr 0x100, mem_ack 2 cycles after mem_req with rdata 0xDEADBEEF -> i_ready cycle 0, mem_req cycles 1-2, i_rvalid cycle 3 with 0xDEADBEEF, i_err=0.
REQ-031 Out of reset, i_req and d_req high together, held -> order fetch, data, fetch, data; mem_addr matches each winner.
REQ-032 d_req write, addr 0x40, wdata 0x12345678, wstrb 0b0011 -> mem_we=1, mem_wstrb=0b0011, mem_wdata=0x12345678; d_rvalid with d_rdata=0 after ack.
REQ-033 TIMEOUT=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then d_rvalid=1, d_err=1, d_rdata=0; a new grant is possible 1 cycle later.
REQ-034 rst pulsed mid-BUSY, then mem_ack -> mem_req drops asynchronously, no rvalid on either port, state IDLE.
REQ-035 mem_ack pulsed while IDLE with no request -> no outputs change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and requester ids.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   typedef enum logic {
      PORT_I,
      PORT_D
   } port_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port around mem_arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ready;
   logic              i_rvalid;
   logic              i_err;
   logic [DATA_W-1:0] i_rdata;

   logic                d_req;
   logic                d_we;
   logic [ADDR_W-1:0]   d_addr;
   logic [DATA_W-1:0]   d_wdata;
   logic [DATA_W/8-1:0] d_wstrb;
   logic                d_ready;
   logic                d_rvalid;
   logic                d_err;
   logic [DATA_W-1:0]   d_rdata;

   logic                mem_req;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic                mem_ack;
   logic [DATA_W-1:0]   mem_rdata;

   // Arbiter side.
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
      output i_ready, i_rvalid, i_err, i_rdata, d_ready, d_rvalid, d_err, d_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   // Requesters and memory side.
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
      input  i_ready, i_rvalid, i_err, i_rdata, d_ready, d_rvalid, d_err, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-request round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic  fetch_req,
   input  logic  data_req,
   input  port_t last_grant,
   output logic  grant,
   output port_t port
);

   always_comb begin
      grant = fetch_req | data_req;
      port  = PORT_I;
      if (fetch_req && data_req)
         port = (last_grant == PORT_D) ? PORT_I : PORT_D;
      else if (data_req)
         port = PORT_D;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-fetch and a data requester,
// one transaction at a time, with a bounded wait for the memory acknowledge.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t              state;
   port_t               last_grant;
   port_t               owner;
   logic [CNT_W-1:0]    cnt;

   logic                grant;
   port_t               pick;
   logic                take;
   logic                timed_out;
   logic [ADDR_W-1:0]   grant_addr;
   logic [DATA_W-1:0]   grant_wdata;
   logic [DATA_W/8-1:0] grant_wstrb;
   logic                grant_we;
   logic [DATA_W-1:0]   resp_data;

   rr_arbiter2 u_rr (
      .fetch_req  (bus.i_req),
      .data_req   (bus.d_req),
      .last_grant (last_grant),
      .grant      (grant),
      .port       (pick)
   );

   // Ready is combinational so the winner sees acceptance in its request cycle.
   assign take        = !rst && (state == IDLE) && grant;
   assign bus.i_ready = take && (pick == PORT_I);
   assign bus.d_ready = take && (pick == PORT_D);

   assign grant_addr  = (pick == PORT_I) ? bus.i_addr : bus.d_addr;
   assign grant_we    = (pick == PORT_D) && bus.d_we;
   assign grant_wdata = (pick == PORT_D) ? bus.d_wdata : '0;
   assign grant_wstrb = (pick == PORT_D) ? bus.d_wstrb : '0;

   // An ack on the final counted cycle still wins over the timeout.
   assign timed_out = !bus.mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
   assign resp_data = (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= PORT_D;
         owner         <= PORT_I;
         cnt           <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
         bus.i_rvalid  <= 1'b0;
         bus.i_err     <= 1'b0;
         bus.i_rdata   <= '0;
         bus.d_rvalid  <= 1'b0;
         bus.d_err     <= 1'b0;
         bus.d_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  owner         <= pick;
                  last_grant    <= pick;
                  cnt           <= '0;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= grant_we;
                  bus.mem_addr  <= grant_addr;
                  bus.mem_wdata <= grant_wdata;
                  bus.mem_wstrb <= grant_wstrb;
                  state         <= BUSY;
               end
            end
            BUSY: begin
               if (bus.mem_ack || timed_out) begin
                  bus.mem_req <= 1'b0;
                  state       <= RESP;
                  if (owner == PORT_I) begin
                     bus.i_rvalid <= 1'b1;
                     bus.i_err    <= timed_out;
                     bus.i_rdata  <= resp_data;
                  end else begin
                     bus.d_rvalid <= 1'b1;
                     bus.d_err    <= timed_out;
                     bus.d_rdata  <= resp_data;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               bus.i_rvalid <= 1'b0;
               bus.i_err    <= 1'b0;
               bus.d_rvalid <= 1'b0;
               bus.d_err    <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level timing model of grants, acks, timeouts and responses.
module tb_mem_arbiter;

   localparam int TO = 4;

   logic clk;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_req     = 1'b0;
      bus.i_addr    = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.d_wstrb   = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] addr;
      clear_inputs();
      addr = $urandom;
      rst = 1'b1;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      bus.i_addr = addr;
      bus.d_addr = ~addr;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({bus.i_ready, bus.d_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 00", {bus.i_ready, bus.d_ready});
      end
      n_tests++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== '0) begin
         n_fail++;
         $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h wstrb=%h expected all 0",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      end
      n_tests++;
      if ({bus.i_rvalid, bus.i_err, bus.i_rdata, bus.d_rvalid, bus.d_err, bus.d_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_resp: i=%b/%b/%h d=%b/%b/%h expected all 0",
                  bus.i_rvalid, bus.i_err, bus.i_rdata, bus.d_rvalid, bus.d_err, bus.d_rdata);
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_fetch_read();
      do_reset();
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h100;
      #1;
      n_tests++;
      if ({bus.i_ready, bus.d_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL fetch_ready: got %b expected 10", {bus.i_ready, bus.d_ready});
      end
      next_cycle();
      bus.i_req = 1'b0;
      #1;
      n_tests++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.i_rvalid} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
         n_fail++;
         $display("FAIL fetch_issue: req=%b we=%b addr=%h rvalid=%b expected 1 0 00000100 0",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.i_rvalid);
      end
      next_cycle();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      #1;
      n_tests++;
      if (bus.mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL fetch_req_c2: got %b expected 1", bus.mem_req);
      end
      next_cycle();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      #1;
      n_tests++;
      if ({bus.i_rvalid, bus.i_rdata, bus.i_err, bus.mem_req, bus.d_rvalid} !==
          {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL fetch_resp: rvalid=%b rdata=%h err=%b mem_req=%b d_rvalid=%b expected 1 deadbeef 0 0 0",
                  bus.i_rvalid, bus.i_rdata, bus.i_err, bus.mem_req, bus.d_rvalid);
      end
      next_cycle();
      #1;
      n_tests++;
      if ({bus.i_rvalid, bus.i_rdata} !== {1'b0, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL fetch_hold: rvalid=%b rdata=%h expected 0 deadbeef", bus.i_rvalid, bus.i_rdata);
      end
   endtask

   task automatic test_tie_order();
      logic exp_d;
      do_reset();
      bus.i_req  = 1'b1;
      bus.i_addr = 32'hA0;
      bus.d_req  = 1'b1;
      bus.d_addr = 32'hB0;
      for (int k = 0; k < 4; k++) begin
         exp_d = (k % 2) == 1;
         #1;
         n_tests++;
         if ({bus.i_ready, bus.d_ready} !== {!exp_d, exp_d}) begin
            n_fail++;
            $display("FAIL tie_grant%0d: got %b expected %b", k, {bus.i_ready, bus.d_ready}, {!exp_d, exp_d});
         end
         next_cycle();
         bus.mem_ack = 1'b1;
         #1;
         n_tests++;
         if (bus.mem_addr !== (exp_d ? 32'hB0 : 32'hA0)) begin
            n_fail++;
            $display("FAIL tie_addr%0d: got %h expected %h", k, bus.mem_addr, exp_d ? 32'hB0 : 32'hA0);
         end
         next_cycle();
         bus.mem_ack = 1'b0;
         #1;
         n_tests++;
         if ({bus.i_ready, bus.d_ready, bus.i_rvalid, bus.d_rvalid} !== {2'b00, !exp_d, exp_d}) begin
            n_fail++;
            $display("FAIL tie_resp%0d: ready=%b rvalid=%b expected 00 %b",
                     k, {bus.i_ready, bus.d_ready}, {bus.i_rvalid, bus.d_rvalid}, {!exp_d, exp_d});
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   task automatic test_write();
      do_reset();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'h12345678;
      bus.d_wstrb = 4'b0011;
      #1;
      n_tests++;
      if ({bus.i_ready, bus.d_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL write_ready: got %b expected 01", {bus.i_ready, bus.d_ready});
      end
      next_cycle();
      clear_inputs();
      #1;
      n_tests++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
          {1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011}) begin
         n_fail++;
         $display("FAIL write_issue: req=%b we=%b addr=%h wdata=%h wstrb=%b expected 1 1 40 12345678 0011",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFFFFFF;
      next_cycle();
      bus.mem_ack = 1'b0;
      #1;
      n_tests++;
      if ({bus.d_rvalid, bus.d_rdata, bus.d_err, bus.i_rvalid} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL write_resp: rvalid=%b rdata=%h err=%b i_rvalid=%b expected 1 0 0 0",
                  bus.d_rvalid, bus.d_rdata, bus.d_err, bus.i_rvalid);
      end
   endtask

   task automatic test_timeout();
      int req_cnt;
      int got;
      do_reset();
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h80;
      #1;
      n_tests++;
      if (bus.d_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_ready: got %b expected 1", bus.d_ready);
      end
      next_cycle();
      bus.d_req = 1'b0;
      req_cnt = 0;
      got     = -1;
      for (int w = 1; w <= 10 && got < 0; w++) begin
         #1;
         if (bus.mem_req === 1'b1) req_cnt++;
         if (bus.d_rvalid === 1'b1) begin
            got = w;
            n_tests++;
            if ({bus.d_err, bus.d_rdata} !== {1'b1, 32'h0}) begin
               n_fail++;
               $display("FAIL timeout_resp: err=%b rdata=%h expected 1 0", bus.d_err, bus.d_rdata);
            end
         end
         next_cycle();
      end
      n_tests++;
      if (got != TO + 1 || req_cnt != TO) begin
         n_fail++;
         $display("FAIL timeout_timing: rvalid cycle %0d mem_req cycles %0d expected %0d and %0d",
                  got, req_cnt, TO + 1, TO);
      end
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h200;
      #1;
      n_tests++;
      if (bus.i_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_regrant: got %b expected 1", bus.i_ready);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_busy();
      do_reset();
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h300;
      next_cycle();
      bus.i_req = 1'b0;
      #1;
      n_tests++;
      if (bus.mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre: mem_req got %b expected 1", bus.mem_req);
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async: mem_req got %b expected 0", bus.mem_req);
      end
      next_cycle();
      rst = 1'b0;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = $urandom;
      for (int w = 0; w < 4; w++) begin
         #1;
         n_tests++;
         if ({bus.mem_req, bus.i_rvalid, bus.d_rvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_quiet%0d: req/i_rvalid/d_rvalid got %b expected 000",
                     w, {bus.mem_req, bus.i_rvalid, bus.d_rvalid});
         end
         next_cycle();
         bus.mem_ack = 1'b0;
      end
      bus.d_req = 1'b1;
      #1;
      n_tests++;
      if (bus.d_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_idle: d_ready got %b expected 1", bus.d_ready);
      end
      clear_inputs();
   endtask

   task automatic test_idle_ack();
      do_reset();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hCAFEF00D;
      for (int w = 0; w < 3; w++) begin
         next_cycle();
         bus.mem_ack = 1'b0;
         #1;
         n_tests++;
         if ({bus.mem_req, bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL idle_ack%0d: req=%b rv=%b%b err=%b%b rdata=%h/%h expected all 0", w,
                     bus.mem_req, bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata);
         end
      end
   endtask

   task automatic test_random();
      int          free_cyc, gnt_cyc, resp_cyc, ack_cyc, lat;
      logic        i_pend, d_pend, d_w, owner_d, last_d, win_d, exp_i, exp_d, exp_err, exp_mreq;
      logic [31:0] i_a, d_a, d_wd, rd, exp_rd, last_i_rd, last_d_rd, cap_addr, cap_wd;
      logic [3:0]  d_ws, cap_ws;
      logic        cap_we;
      do_reset();
      free_cyc = 0;  gnt_cyc = -10;  resp_cyc = -10;  ack_cyc = -10;
      i_pend = 0;  d_pend = 0;  owner_d = 0;  last_d = 1;  exp_err = 0;
      i_a = 0;  d_a = 0;  d_wd = 0;  d_ws = 0;  d_w = 0;  rd = 0;  exp_rd = 0;
      last_i_rd = 0;  last_d_rd = 0;  cap_addr = 0;  cap_wd = 0;  cap_ws = 0;  cap_we = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!i_pend && $urandom_range(0, 2) == 0) begin
            i_pend = 1;  i_a = $urandom;
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1;  d_a = $urandom;  d_w = 1'($urandom);  d_wd = $urandom;  d_ws = 4'($urandom);
         end
         bus.i_req = i_pend;  bus.i_addr = i_a;
         bus.d_req = d_pend;  bus.d_addr = d_a;  bus.d_we = d_w;  bus.d_wdata = d_wd;  bus.d_wstrb = d_ws;
         bus.mem_ack   = (cyc == ack_cyc);
         bus.mem_rdata = (cyc == ack_cyc) ? rd : 32'($urandom);
         #1;
         exp_i = 0;  exp_d = 0;
         if (cyc >= free_cyc && (i_pend || d_pend)) begin
            win_d = (i_pend && d_pend) ? !last_d : d_pend;
            exp_i = !win_d;  exp_d = win_d;
         end
         n_tests++;
         if ({bus.i_ready, bus.d_ready} !== {exp_i, exp_d}) begin
            n_fail++;
            $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, {bus.i_ready, bus.d_ready}, {exp_i, exp_d});
         end
         exp_mreq = (cyc > gnt_cyc) && (cyc < resp_cyc);
         n_tests++;
         if (bus.mem_req !== exp_mreq) begin
            n_fail++;
            $display("FAIL rnd_mem_req@%0d: got %b expected %b", cyc, bus.mem_req, exp_mreq);
         end
         if (exp_mreq) begin
            n_tests++;
            if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb} !== {cap_addr, cap_we, cap_wd, cap_ws}) begin
               n_fail++;
               $display("FAIL rnd_mem_fields@%0d: got %h %b %h %h expected %h %b %h %h", cyc,
                        bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb, cap_addr, cap_we, cap_wd, cap_ws);
            end
         end
         n_tests++;
         if ({bus.i_rvalid, bus.d_rvalid} !== {cyc == resp_cyc && !owner_d, cyc == resp_cyc && owner_d}) begin
            n_fail++;
            $display("FAIL rnd_rvalid@%0d: got %b expected %b", cyc, {bus.i_rvalid, bus.d_rvalid},
                     {cyc == resp_cyc && !owner_d, cyc == resp_cyc && owner_d});
         end
         if (cyc == resp_cyc) begin
            if (owner_d) last_d_rd = exp_rd;
            else         last_i_rd = exp_rd;
            n_tests++;
            if ((owner_d ? bus.d_err : bus.i_err) !== exp_err) begin
               n_fail++;
               $display("FAIL rnd_err@%0d: got %b expected %b", cyc, owner_d ? bus.d_err : bus.i_err, exp_err);
            end
         end
         n_tests++;
         if ({bus.i_rdata, bus.d_rdata} !== {last_i_rd, last_d_rd}) begin
            n_fail++;
            $display("FAIL rnd_rdata@%0d: got %h/%h expected %h/%h", cyc, bus.i_rdata, bus.d_rdata, last_i_rd, last_d_rd);
         end
         if (exp_i || exp_d) begin
            lat      = $urandom_range(1, TO + 2);
            rd       = $urandom;
            gnt_cyc  = cyc;
            ack_cyc  = cyc + lat;
            resp_cyc = cyc + 1 + ((lat <= TO) ? lat : TO);
            free_cyc = resp_cyc + 1;
            owner_d  = exp_d;
            last_d   = exp_d;
            if (exp_d) begin
               cap_addr = d_a;  cap_we = d_w;  cap_wd = d_wd;  cap_ws = d_ws;  d_pend = 0;
            end else begin
               cap_addr = i_a;  cap_we = 0;  cap_wd = 0;  cap_ws = 0;  i_pend = 0;
            end
            exp_err = (lat > TO);
            exp_rd  = (exp_err || cap_we) ? 32'h0 : rd;
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_fetch_read();
      test_tie_order();
      test_write();
      test_timeout();
      test_reset_mid_busy();
      test_idle_ack();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
